// File: rtl/rv32_mc_sequencer.sv
// rv32_mc_sequencer: multi-cycle control FSM for the ROC RV32 core.
// Owns PC/IR/ALUOut, imem and LSU handshakes, traps, halt and instret.
module rv32_mc_sequencer #(
  parameter int unsigned ADDR_WIDTH_I = 10,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MEM_TIMEOUT  = 0,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_WIDTH_I-1:0] imem_addr,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_data,
  output logic [31:0]             ir,
  output logic [31:0]             pc_ir,
  input  logic [31:0]             alu_result,
  output logic [31:0]             alu_out,
  input  logic                    branch_cond,
  input  logic [31:0]             target_addr,
  output logic                    rready_cpu,
  input  logic                    rvalid_cpu,
  output logic                    wvalid_cpu,
  input  logic                    wready_cpu,
  output logic                    reg_we,
  output logic [1:0]              wb_sel,
  output logic [2:0]              cpu_state,
  output logic                    trap_valid,
  output logic [3:0]              trap_cause,
  output logic [31:0]             trap_pc,
  output logic [31:0]             trap_tval,
  output logic                    halted,
  input  logic                    resume,
  output logic [CNT_WIDTH-1:0]    instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] mem_cnt;

  logic op_lui, op_auipc, op_jal, op_jalr, op_br;
  logic op_load, op_store, op_opimm, op_op, op_fence, op_sys;
  logic illegal, taken, jump_mis, mem_op, mem_mis;
  logic wb_we, mem_hs, mem_tmo;
  logic [1:0] wb_sel_d;

  assign cpu_state = state;
  assign imem_addr = pc[ADDR_WIDTH_I+1:2];

  assign op_lui   = ir[6:0] == OPC_LUI;
  assign op_auipc = ir[6:0] == OPC_AUIPC;
  assign op_jal   = ir[6:0] == OPC_JAL;
  assign op_jalr  = ir[6:0] == OPC_JALR;
  assign op_br    = ir[6:0] == OPC_BR;
  assign op_load  = ir[6:0] == OPC_LOAD;
  assign op_store = ir[6:0] == OPC_STORE;
  assign op_opimm = ir[6:0] == OPC_OPIMM;
  assign op_op    = ir[6:0] == OPC_OP;
  assign op_fence = ir[6:0] == OPC_FENCE;
  assign op_sys   = ir[6:0] == OPC_SYS;

  // every known opcode ends in 2'b11, so this also rejects compressed words
  assign illegal = !(op_lui | op_auipc | op_jal | op_jalr | op_br |
                     op_load | op_store | op_opimm | op_op |
                     op_fence | op_sys);

  assign taken    = op_jal | op_jalr | (op_br & branch_cond);
  assign jump_mis = taken & (target_addr[1:0] != 2'b00);
  assign mem_op   = op_load | op_store;
  assign mem_mis  = (ir[13:12] == 2'b01 && alu_result[0]) ||
                    (ir[13:12] == 2'b10 && alu_result[1:0] != 2'b00);

  assign wb_we  = op_lui | op_auipc | op_jal | op_jalr |
                  op_op | op_opimm | op_load;
  assign mem_hs = (rready_cpu & rvalid_cpu) | (wvalid_cpu & wready_cpu);
  assign mem_tmo = (MEM_TIMEOUT != 0) &&
                   (mem_cnt == 32'(MEM_TIMEOUT - 1));

  always_comb begin
    wb_sel_d = 2'b00;
    unique case (1'b1)
      op_load:          wb_sel_d = 2'b01;
      op_jal | op_jalr: wb_sel_d = 2'b10;
      op_lui:           wb_sel_d = 2'b11;
      default:          wb_sel_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_FETCH;
      pc             <= RESET_VECTOR;
      next_pc        <= 32'd0;
      mem_cnt        <= 32'd0;
      ir             <= 32'd0;
      pc_ir          <= 32'd0;
      alu_out        <= 32'd0;
      imem_req_valid <= 1'b0;
      rready_cpu     <= 1'b0;
      wvalid_cpu     <= 1'b0;
      reg_we         <= 1'b0;
      wb_sel         <= 2'b00;
      trap_valid     <= 1'b0;
      trap_cause     <= 4'd0;
      trap_pc        <= 32'd0;
      trap_tval      <= 32'd0;
      halted         <= 1'b0;
      instret        <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_DECODE;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_DECODE: begin
          if (imem_rsp_valid) begin
            ir    <= imem_rsp_data;
            pc_ir <= pc;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out <= alu_result;
          next_pc <= taken ? target_addr : pc_ir + 32'd4;
          unique case (1'b1)
            illegal: begin
              trap_valid <= 1'b1;
              trap_cause <= 4'd2;
              trap_tval  <= ir;
              trap_pc    <= pc_ir;
              state      <= S_TRAP;
            end
            jump_mis: begin
              trap_valid <= 1'b1;
              trap_cause <= 4'd0;
              trap_tval  <= target_addr;
              trap_pc    <= pc_ir;
              state      <= S_TRAP;
            end
            mem_op: begin
              if (mem_mis) begin
                trap_valid <= 1'b1;
                trap_cause <= op_load ? 4'd4 : 4'd6;
                trap_tval  <= alu_result;
                trap_pc    <= pc_ir;
                state      <= S_TRAP;
              end else begin
                rready_cpu <= op_load;
                wvalid_cpu <= op_store;
                mem_cnt    <= 32'd0;
                state      <= S_MEM;
              end
            end
            op_sys: begin
              if (ir[31:20] == 12'd1) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                trap_valid <= 1'b1;
                trap_cause <= (ir[31:20] == 12'd0) ? 4'd11 : 4'd2;
                trap_tval  <= (ir[31:20] == 12'd0) ? 32'd0 : ir;
                trap_pc    <= pc_ir;
                state      <= S_TRAP;
              end
            end
            default: begin
              reg_we <= wb_we;
              wb_sel <= wb_sel_d;
              state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_hs) begin
            rready_cpu <= 1'b0;
            wvalid_cpu <= 1'b0;
            reg_we     <= wb_we;
            wb_sel     <= wb_sel_d;
            state      <= S_WB;
          end else if (mem_tmo) begin
            rready_cpu <= 1'b0;
            wvalid_cpu <= 1'b0;
            trap_valid <= 1'b1;
            trap_cause <= op_load ? 4'd5 : 4'd7;
            trap_tval  <= alu_out;
            trap_pc    <= pc_ir;
            state      <= S_TRAP;
          end else begin
            mem_cnt <= mem_cnt + 32'd1;
          end
        end
        S_WB: begin
          reg_we  <= 1'b0;
          pc      <= next_pc;
          instret <= instret + CNT_WIDTH'(1);
          state   <= S_FETCH;
        end
        S_TRAP: begin
          trap_valid <= 1'b0;
          pc         <= TRAP_VECTOR;
          state      <= S_FETCH;
        end
        S_HALT: begin
          if (resume) begin
            halted  <= 1'b0;
            pc      <= pc_ir + 32'd4;
            instret <= instret + CNT_WIDTH'(1);
            state   <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
